// File: rtl/flex_aggregator_pkg.sv
// Shared types and helpers for the flex_aggregator packer: packer state,
// lane-valid mask construction and fetch-width legality.
package aggregator_pkg;

  typedef enum logic {
    PK_FILL = 1'b0,
    PK_DONE = 1'b1
  } pk_state_e;

  // Low `cnt` bits set; callers truncate to their lane count.
  function automatic logic [63:0] lane_mask(input int unsigned cnt);
    if (cnt >= 64) return '1;
    return (64'd1 << cnt) - 64'd1;
  endfunction

  function automatic logic width_legal(input int unsigned w, input int unsigned max_w);
    return (w >= 1) && (w <= max_w);
  endfunction

endpackage

// File: rtl/flex_aggregator_if.sv
// Sender/receiver/control bundle of flex_aggregator; the aggregator is the
// master side, the surrounding FIFOs and controller the slave side.
interface flex_aggregator_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_FETCH_WIDTH = 4,
  parameter int CNT_W           = $clog2(MAX_FETCH_WIDTH + 1)
);
  logic [DATA_WIDTH-1:0]                 sender_data;
  logic                                  sender_empty_n;
  logic                                  sender_deq;
  logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data;
  logic [MAX_FETCH_WIDTH-1:0]            receiver_valid_mask;
  logic                                  receiver_full_n;
  logic                                  receiver_enq;
  logic                                  change_fetch_width;
  logic [CNT_W-1:0]                      input_fetch_width;
  logic                                  flush;
  logic                                  width_err;

  modport master (
    input  sender_data, sender_empty_n, receiver_full_n,
    input  change_fetch_width, input_fetch_width, flush,
    output sender_deq, receiver_data, receiver_valid_mask, receiver_enq, width_err
  );

  modport slave (
    output sender_data, sender_empty_n, receiver_full_n,
    output change_fetch_width, input_fetch_width, flush,
    input  sender_deq, receiver_data, receiver_valid_mask, receiver_enq, width_err
  );

endinterface

// File: rtl/flex_aggregator_out_reg.sv
// Output holding register: captures a finished packed word and presents it
// until the receiver accepts it.
module aggregator_out_reg #(
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [MASK_W-1:0] load_mask,
  input  logic              full_n,
  output logic [DATA_W-1:0] out_data,
  output logic [MASK_W-1:0] out_mask,
  output logic              out_valid,
  output logic              enq
);

  // Reset gates the transfer combinationally so it drops in the reset cycle.
  assign enq = out_valid && full_n && !rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_mask  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_mask  <= load_mask;
      out_valid <= 1'b1;
    end else if (enq) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/flex_aggregator.sv
// Packs DATA_WIDTH sender words into MAX_FETCH_WIDTH-lane receiver words with
// a runtime packing ratio, flush of partial words and a decoupled output slot.
module flex_aggregator
  import aggregator_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_FETCH_WIDTH = 4,
  parameter int CNT_W           = $clog2(MAX_FETCH_WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  flex_aggregator_if.master bus
);

  localparam int               TOTAL_W = DATA_WIDTH * MAX_FETCH_WIDTH;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FETCH_WIDTH);

  pk_state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]      pack_lane [MAX_FETCH_WIDTH];
  logic [CNT_W-1:0]           pack_cnt, base_cnt, cnt_next;
  logic [CNT_W-1:0]           fw, pend_fw;
  logic                       pend_vld, width_err_q;
  logic                       out_valid, out_free, load_out, deq, enq;
  logic                       req_legal, apply_fw;
  logic [TOTAL_W-1:0]         load_data;
  logic [MAX_FETCH_WIDTH-1:0] load_mask;

  assign out_free = !out_valid || enq;
  assign load_out = (state_q == PK_DONE) && out_free;
  assign deq      = bus.sender_empty_n && !rst &&
                    ((state_q == PK_FILL) || ((state_q == PK_DONE) && out_free));

  // A word handed to the output slot frees the packer in the same cycle, so a
  // concurrent dequeue lands in lane 0 of the fresh packer.
  assign base_cnt = load_out ? '0 : pack_cnt;
  assign cnt_next = base_cnt + CNT_W'(deq);

  // Width changes only land on an idle, empty packer so a word in progress
  // always finishes at the width it started with.
  assign req_legal = width_legal(32'(bus.input_fetch_width), 32'(MAX_FETCH_WIDTH));
  assign apply_fw  = pend_vld && (pack_cnt == '0) && !deq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PK_FILL;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a value held and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if ((state_q == PK_FILL) || load_out) begin
      if ((cnt_next == fw) || (bus.flush && (cnt_next != '0))) state_d = PK_DONE;
      else                                                     state_d = PK_FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_cnt    <= '0;
      fw          <= MAX_CNT;
      pend_fw     <= MAX_CNT;
      pend_vld    <= 1'b0;
      width_err_q <= 1'b0;
    end else begin
      pack_cnt    <= cnt_next;
      width_err_q <= bus.change_fetch_width && !req_legal;
      if (apply_fw) fw <= pend_fw;
      if (bus.change_fetch_width && req_legal) begin
        pend_fw  <= bus.input_fetch_width;
        pend_vld <= 1'b1;
      end else if (apply_fw) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // NOTE: the lane storage has no reset; pack_cnt and the lane mask decide
  // what is live, and stale lanes are zeroed on their way to the output.
  always_ff @(posedge clk) begin
    for (int k = 0; k < MAX_FETCH_WIDTH; k++) begin
      if (deq && (base_cnt == CNT_W'(k))) pack_lane[k] <= bus.sender_data;
    end
  end

  always_comb begin
    load_mask = MAX_FETCH_WIDTH'(lane_mask(32'(pack_cnt)));
    load_data = '0;
    for (int k = 0; k < MAX_FETCH_WIDTH; k++) begin
      load_data[k*DATA_WIDTH +: DATA_WIDTH] = load_mask[k] ? pack_lane[k] : '0;
    end
  end

  aggregator_out_reg #(
    .DATA_W (TOTAL_W),
    .MASK_W (MAX_FETCH_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_out),
    .load_data (load_data),
    .load_mask (load_mask),
    .full_n    (bus.receiver_full_n),
    .out_data  (bus.receiver_data),
    .out_mask  (bus.receiver_valid_mask),
    .out_valid (out_valid),
    .enq       (enq)
  );

  assign bus.sender_deq   = deq;
  assign bus.receiver_enq = enq;
  assign bus.width_err    = width_err_q;

endmodule

// File: tb/tb_flex_aggregator.sv
// Scoreboard bench for flex_aggregator: a word-level model groups consumed
// words into expected output words; a negedge monitor compares every transfer.
module tb_flex_aggregator;

  localparam int DW   = 8;
  localparam int MAXF = 4;
  localparam int CW   = $clog2(MAXF + 1);
  localparam int TW   = DW * MAXF;

  typedef struct {
    logic [TW-1:0]   data;
    logic [MAXF-1:0] mask;
    int              close_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  flex_aggregator_if #(.DATA_WIDTH(DW), .MAX_FETCH_WIDTH(MAXF)) bus ();

  flex_aggregator #(.DATA_WIDTH(DW), .MAX_FETCH_WIDTH(MAXF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   n_enq = 0;
  exp_t exp_q[$];
  int   acc[$];
  int   model_fw = MAXF;
  int   model_pend = 0;
  int   next_word = 0;
  bit   consumed = 1'b0;
  bit   src_on = 1'b0;
  int   src_limit = 0;
  int   stall_pct = 0;
  int   rx_pct = 100;
  bit   lat_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void close_group(input int c);
    exp_t e;
    e.data = '0;
    e.mask = '0;
    foreach (acc[i]) begin
      e.data[i*DW +: DW] = DW'(acc[i]);
      e.mask[i] = 1'b1;
    end
    e.close_cyc = c;
    exp_q.push_back(e);
    acc.delete();
  endfunction

  // A pending width takes effect for the next group that starts after it.
  function automatic void model_word(input int w, input int c);
    if (acc.size() == 0 && model_pend != 0) begin
      model_fw   = model_pend;
      model_pend = 0;
    end
    acc.push_back(w);
    if (acc.size() == model_fw) close_group(c);
  endfunction

  always @(posedge clk) cyc++;

  // Sender FIFO: presents consecutive integers, advancing once consumed.
  initial begin
    bus.sender_data    = '0;
    bus.sender_empty_n = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (consumed) begin
        next_word++;
        consumed = 1'b0;
      end
      bus.sender_data    = DW'(next_word);
      bus.sender_empty_n = src_on && (next_word < src_limit) &&
                           ($urandom_range(99) >= stall_pct);
    end
  end

  initial begin
    bus.receiver_full_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.receiver_full_n = ($urandom_range(99) < rx_pct);
    end
  end

  // Model feed and scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sender_deq) begin
        check("deq_needs_data", 64'(bus.sender_empty_n), 1);
        consumed = 1'b1;
        model_word(next_word % 256, cyc);
      end
      if (bus.flush && acc.size() != 0) close_group(cyc);
      if (bus.receiver_enq) begin
        check("enq_has_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rx_data", 64'(bus.receiver_data), 64'(e.data));
          check("rx_mask", 64'(bus.receiver_valid_mask), 64'(e.mask));
          if (lat_mode) check("latency", 64'(cyc - e.close_cyc), 2);
          n_enq++;
        end
      end
    end
  end

  task automatic wait_words(input int target, input int budget);
    int n = 0;
    while (next_word < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("words_consumed", 64'(next_word), 64'(target));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    check("drained", 64'(exp_q.size()), 0);
  endtask

  task automatic set_width(input int w);
    bit legal;
    legal = (w >= 1) && (w <= MAXF);
    bus.input_fetch_width  = CW'(w);
    bus.change_fetch_width = 1'b1;
    if (legal) model_pend = w;
    @(posedge clk);
    #2;
    bus.change_fetch_width = 1'b0;
    @(negedge clk);
    check("width_err_pulse", 64'(bus.width_err), legal ? 64'd0 : 64'd1);
    @(negedge clk);
    check("width_err_clear", 64'(bus.width_err), 0);
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(posedge clk);
    #2;
    bus.flush = 1'b0;
  endtask

  initial begin
    int base;
    bus.change_fetch_width = 1'b0;
    bus.input_fetch_width  = '0;
    bus.flush              = 1'b0;

    // Reset values.
    #1 rst = 1'b1;
    #1;
    check("rst_data", 64'(bus.receiver_data), 0);
    check("rst_mask", 64'(bus.receiver_valid_mask), 0);
    check("rst_enq", 64'(bus.receiver_enq), 0);
    check("rst_deq", 64'(bus.sender_deq), 0);
    check("rst_width_err", 64'(bus.width_err), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #2;

    // fw=4 under random receiver back-pressure and sender stalls.
    src_on    = 1'b1;
    stall_pct = 30;
    rx_pct    = 60;
    src_limit = 1 << 30;
    repeat (200) @(posedge clk);
    #2;
    src_limit = ((next_word / 4) + 1) * 4;
    rx_pct    = 100;
    stall_pct = 0;
    wait_words(src_limit, 200);
    wait_drain(100);

    // fw=2, receiver always ready: two-cycle cadence and latency.
    lat_mode = 1'b1;
    set_width(2);
    base = next_word;
    src_limit = base + 12;
    wait_words(src_limit, 100);
    wait_drain(50);

    // Width lowered to 1 mid-word: current word finishes at 4 lanes.
    set_width(4);
    base = next_word;
    src_limit = base + 8;
    wait_words(base + 5, 50);
    set_width(1);
    wait_words(base + 8, 50);
    wait_drain(50);
    src_limit = base + 16;
    set_width(0);
    set_width(5);
    wait_words(base + 16, 50);
    wait_drain(50);

    // Flush of a three-lane partial word, then flush on an empty packer.
    set_width(4);
    base = next_word;
    src_limit = base + 3;
    wait_words(src_limit, 50);
    repeat (3) @(posedge clk);
    #2;
    pulse_flush();
    wait_drain(50);
    pulse_flush();
    wait_drain(20);
    src_limit = base + 7;
    wait_words(src_limit, 50);
    wait_drain(50);

    // Reset with the output held and the packer holding two words.
    set_width(2);
    lat_mode  = 1'b0;
    rx_pct    = 0;
    base      = next_word;
    src_limit = base + 4;
    wait_words(src_limit, 50);
    repeat (4) @(posedge clk);
    #2;
    rx_pct = 100;
    bus.receiver_full_n = 1'b1;
    bus.sender_empty_n  = 1'b1;
    #1;
    check("pre_rst_enq", 64'(bus.receiver_enq), 1);
    check("pre_rst_deq", 64'(bus.sender_deq), 1);
    rst = 1'b1;
    #1;
    check("rst_now_enq", 64'(bus.receiver_enq), 0);
    check("rst_now_deq", 64'(bus.sender_deq), 0);
    check("rst_now_mask", 64'(bus.receiver_valid_mask), 0);
    exp_q.delete();
    acc.delete();
    model_fw   = MAXF;
    model_pend = 0;
    consumed   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #2;
    lat_mode  = 1'b1;
    src_limit = next_word + 8;
    wait_words(src_limit, 50);
    wait_drain(50);

    check("enq_seen", 64'(n_enq > 30), 1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
